mem_arbiter: RTL and testbench

Shares the single-port unified instruction/data memory between the fetch stage and the load/store stage of the RISC-V core. Arbitrates requests, sequences each memory access through a fixed-latency FSM, returns read data and completion pulses, and drives a pipeline stall. Sits between the pipeline (PC/fetch and memory stage) and the memory macro.

---
 rtl/types_pkg.sv | 19 +
 rtl/arb_lat_counter.sv | 27 ++
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the unified-memory arbiter: data bus width, FSM states and
// requester identities.
package types_pkg;

    localparam int unsigned DATA_BUS_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state;

    typedef enum logic {
        PORT_FETCH,
        PORT_DATA
    } arb_port;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with zero flag; times the WAIT phase of a memory access.
module arb_lat_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for the single-port unified memory.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter
    import types_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = DATA_BUS_W,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state r_state;
    arb_state w_state_nxt;
    arb_port  r_port;
    arb_port  w_grant_port;
    logic     r_we;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_f_done;
    logic              r_d_done;
    logic [DATA_W-1:0] r_f_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_grant;
    logic              w_force_fetch;
    logic              w_lat_load;
    logic              w_lat_dec;
    logic              w_lat_zero;
    logic              w_mem_en_nxt;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_f_done_nxt;
    logic              w_d_done_nxt;
    logic              w_cap_f;
    logic              w_cap_d;

    assign w_grant      = (r_state == IDLE) && (f_req || d_req);
    assign w_grant_port = (d_req && !w_force_fetch) ? PORT_DATA : PORT_FETCH;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] r_starve_cnt;

    // Counts data grants that bypassed a waiting fetch; saturates at STARVE_MAX
    // because reaching it forces the next contested grant to fetch.
    assign w_force_fetch = f_req && (r_starve_cnt == STARVE_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            if (w_grant_port == PORT_FETCH) begin
                r_starve_cnt <= '0;
            end else if (f_req) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_starve;

    assign w_force_fetch   = 1'b0;
    assign w_unused_starve = ^STARVE_MAX;
`endif

    assign w_lat_load = (r_state == ISSUE);
    assign w_lat_dec  = (r_state == WAIT);

    arb_lat_counter #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_lat_load),
        .i_load_val (CNT_W'(MEM_LAT - 1)),
        .i_dec      (w_lat_dec),
        .o_zero     (w_lat_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (f_req || d_req) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_lat_zero) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for the registered memory strobes, done pulses and captures.
    always_comb begin
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_f_done_nxt    = 1'b0;
        w_d_done_nxt    = 1'b0;
        w_cap_f         = 1'b0;
        w_cap_d         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_mem_en_nxt = 1'b1;
                    if (w_grant_port == PORT_DATA) begin
                        w_mem_we_nxt    = d_we;
                        w_mem_addr_nxt  = d_addr;
                        w_mem_wdata_nxt = d_wdata;
                    end else begin
                        w_mem_addr_nxt  = f_addr;
                    end
                end
            end
            WAIT: begin
                if (w_lat_zero) begin
                    w_f_done_nxt = (r_port == PORT_FETCH);
                    w_d_done_nxt = (r_port == PORT_DATA);
                    w_cap_f      = (r_port == PORT_FETCH);
                    w_cap_d      = (r_port == PORT_DATA) && !r_we;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_port      <= PORT_FETCH;
            r_we        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_f_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_f_done    <= w_f_done_nxt;
            r_d_done    <= w_d_done_nxt;
            if (w_grant) begin
                r_port <= w_grant_port;
                r_we   <= w_mem_we_nxt;
            end
            if (w_cap_f) begin
                r_f_rdata <= mem_rdata;
            end
            if (w_cap_d) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign f_done    = r_f_done;
    assign d_done    = r_d_done;
    assign f_rdata   = r_f_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall     = (f_req & ~r_f_done) | (d_req & ~r_d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3)
// sharing a clock, each with a memory model that returns data only in the valid cycle.
module tb_mem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    typedef struct {
        logic          is_data;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_f;
        logic [DW-1:0] exp_d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       [2];
    logic          f_req     [2];
    logic [AW-1:0] f_addr    [2];
    logic          d_req     [2];
    logic          d_we      [2];
    logic [AW-1:0] d_addr    [2];
    logic [DW-1:0] d_wdata   [2];
    logic [DW-1:0] mem_rdata_v [2];

    logic          f_done_o  [2];
    logic [DW-1:0] f_rdata_o [2];
    logic          d_done_o  [2];
    logic [DW-1:0] d_rdata_o [2];
    logic          mem_en_o  [2];
    logic          mem_we_o  [2];
    logic [AW-1:0] mem_addr_o  [2];
    logic [DW-1:0] mem_wdata_o [2];
    logic          stall_o   [2];

    exp_t          sb_q [2][$];
    logic          free_run [2];
    logic [DW-1:0] last_f [2];
    logic [DW-1:0] last_d [2];
    int            cyc = 0;
    int            m_issue [2] = '{-100, -100};
    logic [AW-1:0] m_addr  [2];
    int            fd_cnt  [2] = '{0, 0};
    int            dd_cnt  [2] = '{0, 0};
    int            slo_cnt [2] = '{0, 0};
    int            n_vec  = 0;
    int            n_miss = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_W     (AW),
            .DATA_W     (DW),
            .MEM_LAT    ((g == 0) ? LAT0 : LAT1),
            .STARVE_MAX (2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .f_req     (f_req[g]),
            .f_addr    (f_addr[g]),
            .f_done    (f_done_o[g]),
            .f_rdata   (f_rdata_o[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_done    (d_done_o[g]),
            .d_rdata   (d_rdata_o[g]),
            .mem_en    (mem_en_o[g]),
            .mem_we    (mem_we_o[g]),
            .mem_addr  (mem_addr_o[g]),
            .mem_wdata (mem_wdata_o[g]),
            .mem_rdata (mem_rdata_v[g]),
            .stall     (stall_o[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input logic is_data, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        exp_t e;
        if (!we) begin
            if (is_data) last_d[k] = mem_word(addr);
            else         last_f[k] = mem_word(addr);
        end
        e.is_data = is_data;
        e.we      = we;
        e.addr    = addr;
        e.wdata   = wdata;
        e.exp_f   = last_f[k];
        e.exp_d   = last_d[k];
        sb_q[k].push_back(e);
    endtask

    task automatic wait_done(input int k, input int maxc, output int n);
        n = 0;
        @(negedge clk);
        while (f_done_o[k] !== 1'b1 && d_done_o[k] !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk_val("wait_done_timeout", 64'(n), 64'(maxc - 1));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns the real word only MEM_LAT cycles after the mem_en cycle.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            if (cyc == m_issue[k] + lat_of(k)) mem_rdata_v[k] = mem_word(m_addr[k]);
            else                                mem_rdata_v[k] = 32'hBAD0_0000 | 32'(cyc[15:0]);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (mem_en_o[k] === 1'b1) begin
                m_issue[k] = cyc;
                m_addr[k]  = mem_addr_o[k];
                if (free_run[k] !== 1'b1) begin
                    chk_val("issue_pending", 64'(sb_q[k].size() != 0), 64'd1);
                    if (sb_q[k].size() != 0) begin
                        e = sb_q[k][0];
                        chk_val("issue_addr", 64'(mem_addr_o[k]), 64'(e.addr));
                        chk_val("issue_we", 64'(mem_we_o[k]), 64'(e.we));
                        if (e.we) chk_val("issue_wdata", 64'(mem_wdata_o[k]), 64'(e.wdata));
                    end
                end
            end
            if (free_run[k] === 1'b1) begin
                if (f_done_o[k] === 1'b1) fd_cnt[k]++;
                if (d_done_o[k] === 1'b1) dd_cnt[k]++;
                if (stall_o[k] !== 1'b1) slo_cnt[k]++;
            end else if (f_done_o[k] === 1'b1 || d_done_o[k] === 1'b1) begin
                chk_val("done_pending", 64'(sb_q[k].size() != 0), 64'd1);
                if (sb_q[k].size() != 0) begin
                    e = sb_q[k].pop_front();
                    chk_val("done_port", 64'({f_done_o[k], d_done_o[k]}),
                            e.is_data ? 64'd1 : 64'd2);
                    chk_val("done_latency", 64'(cyc), 64'(m_issue[k] + lat_of(k) + 1));
                    chk_val("done_f_rdata", 64'(f_rdata_o[k]), 64'(e.exp_f));
                    chk_val("done_d_rdata", 64'(d_rdata_o[k]), 64'(e.exp_d));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int f0, d0, s0;
        for (int k = 0; k < 2; k++) begin
            rst[k]      = 1'b0;
            f_req[k]    = 1'b0;
            f_addr[k]   = '0;
            d_req[k]    = 1'b0;
            d_we[k]     = 1'b0;
            d_addr[k]   = '0;
            d_wdata[k]  = '0;
            free_run[k] = 1'b0;
            last_f[k]   = '0;
            last_d[k]   = '0;
        end
        repeat (2) tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk_val("rst_mem_en", 64'(mem_en_o[k]), 64'd0);
            chk_val("rst_mem_we", 64'(mem_we_o[k]), 64'd0);
            chk_val("rst_mem_addr", 64'(mem_addr_o[k]), 64'd0);
            chk_val("rst_mem_wdata", 64'(mem_wdata_o[k]), 64'd0);
            chk_val("rst_f_done", 64'(f_done_o[k]), 64'd0);
            chk_val("rst_d_done", 64'(d_done_o[k]), 64'd0);
            chk_val("rst_f_rdata", 64'(f_rdata_o[k]), 64'd0);
            chk_val("rst_d_rdata", 64'(d_rdata_o[k]), 64'd0);
        end
        tick();
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // Single fetch, MEM_LAT=1
        tick();
        f_req[0] = 1'b1; f_addr[0] = 32'h100;
        push_exp(0, 1'b0, 1'b0, 32'h100, '0);
        @(negedge clk); chk_val("A_stall_c0", 64'(stall_o[0]), 64'd1);
        tick(); @(negedge clk);
        chk_val("A_mem_en_c1", 64'(mem_en_o[0]), 64'd1);
        chk_val("A_mem_addr_c1", 64'(mem_addr_o[0]), 64'h100);
        chk_val("A_mem_we_c1", 64'(mem_we_o[0]), 64'd0);
        chk_val("A_stall_c1", 64'(stall_o[0]), 64'd1);
        tick(); @(negedge clk);
        chk_val("A_mem_en_c2", 64'(mem_en_o[0]), 64'd0);
        chk_val("A_f_done_c2", 64'(f_done_o[0]), 64'd0);
        chk_val("A_stall_c2", 64'(stall_o[0]), 64'd1);
        tick(); @(negedge clk);
        chk_val("A_f_done_c3", 64'(f_done_o[0]), 64'd1);
        chk_val("A_f_rdata_c3", 64'(f_rdata_o[0]), 64'hDEADBEEF);
        chk_val("A_stall_c3", 64'(stall_o[0]), 64'd0);
        tick();
        f_req[0] = 1'b0;

        // Simultaneous fetch and store: data wins
        tick();
        f_req[0] = 1'b1; f_addr[0] = 32'h200;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h400; d_wdata[0] = 32'h12345678;
        push_exp(0, 1'b1, 1'b1, 32'h400, 32'h12345678);
        push_exp(0, 1'b0, 1'b0, 32'h200, '0);
        tick(); @(negedge clk);
        chk_val("B_mem_we_c1", 64'(mem_we_o[0]), 64'd1);
        chk_val("B_mem_addr_c1", 64'(mem_addr_o[0]), 64'h400);
        chk_val("B_mem_wdata_c1", 64'(mem_wdata_o[0]), 64'h12345678);
        tick(); tick(); @(negedge clk);
        chk_val("B_d_done_c3", 64'(d_done_o[0]), 64'd1);
        chk_val("B_f_done_c3", 64'(f_done_o[0]), 64'd0);
        tick();
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        @(negedge clk); chk_val("B_mem_en_c4", 64'(mem_en_o[0]), 64'd0);
        tick(); @(negedge clk);
        chk_val("B_mem_en_c5", 64'(mem_en_o[0]), 64'd1);
        chk_val("B_mem_addr_c5", 64'(mem_addr_o[0]), 64'h200);
        chk_val("B_mem_we_c5", 64'(mem_we_o[0]), 64'd0);
        tick(); tick(); @(negedge clk);
        chk_val("B_f_done_c7", 64'(f_done_o[0]), 64'd1);
        chk_val("B_stall_c7", 64'(stall_o[0]), 64'd0);
        tick();
        f_req[0] = 1'b0;

        // Reset mid-transaction, MEM_LAT=3, fetch held through reset
        tick();
        f_req[1] = 1'b1; f_addr[1] = 32'h300;
        push_exp(1, 1'b0, 1'b0, 32'h300, '0);
        tick(); tick(); tick();
        sb_q[1].delete();
        last_f[1] = '0;
        last_d[1] = '0;
        rst[1] = 1'b0;
        @(negedge clk); chk_val("C_f_done_c3", 64'(f_done_o[1]), 64'd0);
        tick();
        rst[1] = 1'b1;
        push_exp(1, 1'b0, 1'b0, 32'h300, '0);
        @(negedge clk);
        chk_val("C_mem_en_c4", 64'(mem_en_o[1]), 64'd0);
        chk_val("C_f_done_c4", 64'(f_done_o[1]), 64'd0);
        tick(); @(negedge clk);
        chk_val("C_mem_en_c5", 64'(mem_en_o[1]), 64'd1);
        repeat (3) tick();
        @(negedge clk); chk_val("C_f_done_c8", 64'(f_done_o[1]), 64'd0);
        tick(); @(negedge clk);
        chk_val("C_f_done_c9", 64'(f_done_o[1]), 64'd1);
        chk_val("C_f_rdata_c9", 64'(f_rdata_o[1]), 64'(mem_word(32'h300)));
        tick();
        f_req[1] = 1'b0;

        // Load then store on both latencies; store must leave d_rdata alone
        for (int k = 0; k < 2; k++) begin
            tick();
            d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h80;
            push_exp(k, 1'b1, 1'b0, 32'h80, '0);
            wait_done(k, 20, n);
            chk_val("D_load_cycles", 64'(n), 64'(lat_of(k) + 2));
            chk_val("D_load_rdata", 64'(d_rdata_o[k]), 64'(mem_word(32'h80)));
            tick();
            d_we[k] = 1'b1; d_addr[k] = 32'h84 + 32'(k); d_wdata[k] = 32'hCAFE_F00D ^ 32'(k);
            push_exp(k, 1'b1, 1'b1, 32'h84 + 32'(k), 32'hCAFE_F00D ^ 32'(k));
            wait_done(k, 20, n);
            chk_val("D_store_cycles", 64'(n), 64'(lat_of(k) + 2));
            chk_val("D_store_keeps_rdata", 64'(d_rdata_o[k]), 64'(mem_word(32'h80)));
            tick();
            d_req[k] = 1'b0; d_we[k] = 1'b0;
        end

        // Both requesters held continuously on the MEM_LAT=1 instance
`ifdef ARB_STARVE_GUARD_EN
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40;
        f_req[0] = 1'b1; f_addr[0] = 32'h44;
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 1'b1, 1'b0, 32'h40, '0);
            push_exp(0, 1'b1, 1'b0, 32'h40, '0);
            push_exp(0, 1'b0, 1'b0, 32'h44, '0);
        end
        n = 0;
        while (sb_q[0].size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk_val("F_guard_order_drained", 64'(sb_q[0].size()), 64'd0);
        d_req[0] = 1'b0;
        f_req[0] = 1'b0;
`else
        tick();
        free_run[0] = 1'b1;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40;
        f_req[0] = 1'b1; f_addr[0] = 32'h44;
        f0 = fd_cnt[0]; d0 = dd_cnt[0]; s0 = slo_cnt[0];
        repeat (50) tick();
        chk_val("F_strict_no_f_done", 64'(fd_cnt[0] - f0), 64'd0);
        chk_val("F_strict_stall_held", 64'(slo_cnt[0] - s0), 64'd0);
        chk_val("F_strict_data_progress", 64'((dd_cnt[0] - d0) > 0), 64'd1);
        d_req[0] = 1'b0;
        f_req[0] = 1'b0;
        repeat (LAT0 + 4) tick();
        free_run[0] = 1'b0;
        last_d[0] = mem_word(32'h40);
`endif

        n = 0;
        while ((sb_q[0].size() + sb_q[1].size()) != 0 && n < 100) begin
            tick();
            n++;
        end
        chk_val("final_sb_empty", 64'(sb_q[0].size() + sb_q[1].size()), 64'd0);
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
